ecc_secded_corr_pipe: RTL
=========================

Name: ecc_secded_corr_pipe

Overview:
- Parametrised SECDED check-and-correct pipeline.
- Successor to the team's detect-only Hamming checker; it adds single-bit correction, a valid/ready handshake, error classification, saturating error counters and a first-error log.
- Sits between ECC-protected storage (cache data arrays, register-file spill, DRAM read return) and its consumer.
- Accepts codewords in the existing Hamming layout: check bits at power-of-two positions, overall parity in the MSB.

Parameters:
- DATA_W, 32: payload width in bits.
- CHK_W, 6: Hamming check bits. Must be the smallest k with 2^k >= DATA_W+k+1. Illegal values are an elaboration error.
- TAG_W, 8: width of the sideband tag (address/ID) carried with each word.
- CNT_W, 16: width of the error counters.
- CW_W, DATA_W+CHK_W+1 (localparam): codeword width. 39 by default.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_vld  in  1  input codeword valid
- in_rdy  out  1  pipeline can accept a word
- in_cw  in  CW_W  codeword. Hamming position p is at bit p-1; overall parity is at bit CW_W-1.
- in_tag  in  TAG_W  sideband tag
- corr_en  in  1  1 = correct single-bit errors; 0 = detect only
- out_vld  out  1  output valid
- out_rdy  in  1  consumer accepts
- out_data  out  DATA_W  payload, extracted from non-power-of-two positions in ascending order
- out_tag  out  TAG_W  tag of this word
- out_ce  out  1  corrected (single-bit) error on this word
- out_ue  out  1  uncorrectable error on this word
- out_syn  out  CHK_W  syndrome of this word
- ce_cnt  out  CNT_W  corrected-error count, saturating
- ue_cnt  out  CNT_W  uncorrectable-error count, saturating
- log_vld  out  1  first-error log holds an entry
- log_tag  out  TAG_W  tag of the first erroneous word
- log_syn  out  CHK_W  syndrome of the first erroneous word
- log_ue  out  1  first logged error was uncorrectable
- clr  in  1  synchronous clear of the counters and the log

Behaviour:
- Reset: every valid bit, counter and log register is 0. out_* data/tag/syn are 0. in_rdy is 1 once rst deasserts. Asserting rst mid-stream discards all in-flight words without output.
- Pipeline has two register stages.
  - S1 registers the codeword, tag, syndrome s, overall parity p (XOR of all CW_W bits) and corr_en.
  - S2 registers the corrected data and the flags.
  - Latency from the in_vld&in_rdy cycle to out_vld is 2 cycles; throughput is one word per clk.
- Handshake:
  - A stage loads when it is empty or when its content moves downstream in the same cycle.
  - in_rdy = ~S1.vld | S2 can load.
  - S2 holds its content while out_vld & ~out_rdy.
  - No word is lost or duplicated under any out_rdy pattern. in_rdy has a combinational path from out_rdy.
- Classification:
  - s=0, p=0: clean. ce=0, ue=0.
  - s!=0, p=1, s<=CW_W-1: single error at position s. If corr_en=1, flip bit s-1 before extraction and set ce=1. If corr_en=0, pass data raw and set ue=1.
  - s!=0, p=1, s>CW_W-1: ue=1, data raw.
  - s=0, p=1: parity-bit error. Data is good; ce=1 (regardless of corr_en).
  - s!=0, p=0: double error. ue=1, data raw.
  - ce and ue are never both 1.
- Counters:
  - Count once per word, in the cycle the word is accepted (out_vld&out_rdy) with ce/ue set.
  - Saturate at all-ones.
  - clr has priority over a same-cycle increment; the counter becomes 0.
- Log:
  - Captures tag, syn and ue of the first accepted word with ce|ue while log_vld=0, then sets log_vld.
  - Later errors do not overwrite the log.
  - clr clears log_vld. A clr coinciding with an erroneous acceptance leaves log_vld=0 (clr wins).
- A word stalled in S2 is counted only once, on acceptance.

Test Plan:
- DATA_W=32. Encode 0xDEADBEEF with the team encoder, tag 0x11, out_rdy=1 → out_vld exactly 2 cycles later, out_data=0xDEADBEEF, out_ce=0, out_ue=0, out_syn=0, counters 0.
- Same codeword with bit 4 flipped (position 5), corr_en=1 → out_data=0xDEADBEEF, out_ce=1, out_syn=5, ce_cnt=1, log_vld=1, log_tag=0x11, log_syn=5, log_ue=0. Repeat with corr_en=0 → out_ue=1, raw data, ue_cnt=1.
- Flip bits 2 and 9 → out_ue=1, out_ce=0, ue_cnt increments. Flip only bit 38 → out_ce=1, out_syn=0, data correct.
- Stream 6 back-to-back words with out_rdy low for cycles 3–5 → in_rdy drops once S1 and S2 are full; all 6 words emerge in order with correct tags; an erroneous word stalled in S2 increments its counter once.
- CNT_W=2 with 5 consecutive single-bit errors → ce_cnt goes 1,2,3,3,3. clr in the same cycle as a 6th CE acceptance → ce_cnt=0, log_vld=0.
- Assert rst with 2 words in flight → out_vld=0 the next cycle, counters and log 0. Those words never appear after rst deasserts.

Source files
------------

// File: rtl/ecc_secded_corr_pipe_if.sv
// ecc_secded_corr_pipe_if
// Bundles the upstream codeword channel, the downstream data channel, the
// error counters and the first-error log of ecc_secded_corr_pipe.
//   slave  : the pipeline side (drives in_rdy, out_*, counters, log_*)
//   master : the producer/consumer side (drives in_*, corr_en, out_rdy, clr)
interface ecc_secded_corr_pipe_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
);
  localparam int CW_W = DATA_W + CHK_W + 1;

  logic              in_vld;
  logic              in_rdy;
  logic [CW_W-1:0]   in_cw;
  logic [TAG_W-1:0]  in_tag;
  logic              corr_en;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ce;
  logic              out_ue;
  logic [CHK_W-1:0]  out_syn;
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  ue_cnt;
  logic              log_vld;
  logic [TAG_W-1:0]  log_tag;
  logic [CHK_W-1:0]  log_syn;
  logic              log_ue;
  logic              clr;

  modport slave (
    input  in_vld, in_cw, in_tag, corr_en, out_rdy, clr,
    output in_rdy, out_vld, out_data, out_tag, out_ce, out_ue, out_syn,
           ce_cnt, ue_cnt, log_vld, log_tag, log_syn, log_ue
  );

  modport master (
    output in_vld, in_cw, in_tag, corr_en, out_rdy, clr,
    input  in_rdy, out_vld, out_data, out_tag, out_ce, out_ue, out_syn,
           ce_cnt, ue_cnt, log_vld, log_tag, log_syn, log_ue
  );
endinterface

// File: rtl/ecc_secded_corr_pipe.sv
// ecc_secded_corr_pipe
// Two-stage SECDED check-and-correct pipeline for Hamming codewords
// (check bits at power-of-two positions, overall parity in the MSB).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ecc_secded_corr_pipe_if.slave carrying in_* (codeword in),
//              out_* (corrected data, flags, syndrome), ce_cnt/ue_cnt
//              (saturating error counters), log_* (first-error log), clr.
// Handshake: a word transfers on any cycle where vld & rdy are both high;
// vld, once raised by a sender, is held with stable payload until taken;
// rdy may depend combinationally on the downstream rdy.
module ecc_secded_corr_pipe #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input logic                     clk,
  input logic                     rst,
  ecc_secded_corr_pipe_if.slave   bus
);
  localparam int CW_W = DATA_W + CHK_W + 1;

  function automatic int min_chk(input int dw);
    int k = 1;
    while ((1 << k) < dw + k + 1) k++;
    return k;
  endfunction

  // Hamming position of the idx-th payload bit (skip power-of-two slots).
  function automatic int data_pos(input int idx);
    int cnt = 0;
    int pos = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  if (CHK_W != min_chk(DATA_W)) begin : g_bad_chk
    $error("CHK_W is not the minimal Hamming check width for DATA_W");
  end

  // Stage 1 registers
  logic              r1_vld;
  logic [CW_W-1:0]   r1_cw;
  logic [TAG_W-1:0]  r1_tag;
  logic [CHK_W-1:0]  r1_syn;
  logic              r1_par;
  logic              r1_corr;
  // Stage 2 registers
  logic              r2_vld;
  logic [DATA_W-1:0] r2_data;
  logic [TAG_W-1:0]  r2_tag;
  logic              r2_ce;
  logic              r2_ue;
  logic [CHK_W-1:0]  r2_syn;
  // Counters and log
  logic [CNT_W-1:0]  r_ce_cnt;
  logic [CNT_W-1:0]  r_ue_cnt;
  logic              r_log_vld;
  logic [TAG_W-1:0]  r_log_tag;
  logic [CHK_W-1:0]  r_log_syn;
  logic              r_log_ue;

  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_acc;
  logic [CHK_W-1:0]  w_syn;
  logic              w_par;
  logic [CW_W-1:0]   w_flip;
  logic [CW_W-1:0]   w_cw_fix;
  logic [DATA_W-1:0] w_data;
  logic              w_ce;
  logic              w_ue;

  assign w_s2_load  = ~r2_vld | bus.out_rdy;
  assign w_s1_load  = ~r1_vld | w_s2_load;
  assign w_acc      = r2_vld & bus.out_rdy;
  assign bus.in_rdy = w_s1_load;

  // Syndrome = XOR of the positions of all set bits below the parity MSB.
  always_comb begin
    w_syn = '0;
    for (int p = 1; p < CW_W; p++) begin
      if (bus.in_cw[p-1]) w_syn = w_syn ^ CHK_W'(p);
    end
  end
  assign w_par = ^bus.in_cw;

  // One-hot flip mask; stays zero when the syndrome points past the word.
  always_comb begin
    w_flip = '0;
    for (int p = 1; p < CW_W; p++) begin
      w_flip[p-1] = (r1_syn == CHK_W'(p));
    end
  end

  always_comb begin
    w_ce     = 1'b0;
    w_ue     = 1'b0;
    w_cw_fix = r1_cw;
    if (r1_syn == '0) begin
      w_ce = r1_par;               // only the overall parity bit flipped
    end else if (!r1_par) begin
      w_ue = 1'b1;                 // double error
    end else if (w_flip != '0) begin
      if (r1_corr) begin
        w_ce     = 1'b1;
        w_cw_fix = r1_cw ^ w_flip;
      end else begin
        w_ue = 1'b1;
      end
    end else begin
      w_ue = 1'b1;                 // odd parity but syndrome out of range
    end
  end

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_ext
    assign w_data[gi] = w_cw_fix[data_pos(gi) - 1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld  <= 1'b0;
      r1_cw   <= '0;
      r1_tag  <= '0;
      r1_syn  <= '0;
      r1_par  <= 1'b0;
      r1_corr <= 1'b0;
    end else if (w_s1_load) begin
      r1_vld <= bus.in_vld;
      if (bus.in_vld) begin
        r1_cw   <= bus.in_cw;
        r1_tag  <= bus.in_tag;
        r1_syn  <= w_syn;
        r1_par  <= w_par;
        r1_corr <= bus.corr_en;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_vld  <= 1'b0;
      r2_data <= '0;
      r2_tag  <= '0;
      r2_ce   <= 1'b0;
      r2_ue   <= 1'b0;
      r2_syn  <= '0;
    end else if (w_s2_load) begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_data <= w_data;
        r2_tag  <= r1_tag;
        r2_ce   <= w_ce;
        r2_ue   <= w_ue;
        r2_syn  <= r1_syn;
      end
    end
  end

  // Counting and logging happen only on acceptance, so a stalled word is
  // seen exactly once. clr overrides any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce_cnt  <= '0;
      r_ue_cnt  <= '0;
      r_log_vld <= 1'b0;
      r_log_tag <= '0;
      r_log_syn <= '0;
      r_log_ue  <= 1'b0;
    end else if (bus.clr) begin
      r_ce_cnt  <= '0;
      r_ue_cnt  <= '0;
      r_log_vld <= 1'b0;
      r_log_tag <= '0;
      r_log_syn <= '0;
      r_log_ue  <= 1'b0;
    end else if (w_acc) begin
      if (r2_ce && (r_ce_cnt != '1)) r_ce_cnt <= r_ce_cnt + CNT_W'(1);
      if (r2_ue && (r_ue_cnt != '1)) r_ue_cnt <= r_ue_cnt + CNT_W'(1);
      if ((r2_ce || r2_ue) && !r_log_vld) begin
        r_log_vld <= 1'b1;
        r_log_tag <= r2_tag;
        r_log_syn <= r2_syn;
        r_log_ue  <= r2_ue;
      end
    end
  end

  assign bus.out_vld  = r2_vld;
  assign bus.out_data = r2_data;
  assign bus.out_tag  = r2_tag;
  assign bus.out_ce   = r2_ce;
  assign bus.out_ue   = r2_ue;
  assign bus.out_syn  = r2_syn;
  assign bus.ce_cnt   = r_ce_cnt;
  assign bus.ue_cnt   = r_ue_cnt;
  assign bus.log_vld  = r_log_vld;
  assign bus.log_tag  = r_log_tag;
  assign bus.log_syn  = r_log_syn;
  assign bus.log_ue   = r_log_ue;
endmodule
